// File: rtl/flake_spawn_sched.sv
// Spawn scheduler: shares one LFSR among N_REQ flake slots, granting a per-frame
// budget of spawns round-robin and shaping each fresh random word into column/speed.
module flake_spawn_sched #(
  parameter  int N_REQ = 4,
  parameter  int X_MAX = 639,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             frame_tick_i,
  input  logic [3:0]       level_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic [23:0]      rand_in_i,
  output logic             lfsr_adv_o,
  output logic [N_REQ-1:0] grant_o,
  output logic             spawn_valid_o,
  output logic [9:0]       spawn_x_o,
  output logic [2:0]       spawn_speed_o,
  output logic [IDW-1:0]   spawn_id_o
);

  typedef enum logic [1:0] {IDLE, ADV, WAIT, ISSUE} state_e;

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_e           state_q;
  logic [3:0]       budget_q, quota_d;
  logic [IDW-1:0]   rr_ptr_q, winner_q, win_d, idx;
  logic             win_found_d;
  logic             lfsr_adv_q, spawn_valid_q;
  logic [N_REQ-1:0] grant_q;
  logic [9:0]       raw, spawn_x_q, spawn_x_d;
  logic [2:0]       spawn_speed_q;
  logic [IDW-1:0]   spawn_id_q;
  logic             unused_rand;

  assign unused_rand = ^rand_in_i[23:13];
  assign quota_d     = (level_i > 4'd8) ? 4'd8 : level_i;

  // Columns above X_MAX drop by 512, which always lands inside 0..511.
  assign raw       = rand_in_i[9:0];
  assign spawn_x_d = (raw > 10'(X_MAX)) ? raw - 10'd512 : raw;

  // Round-robin: first requester at or above rr_ptr, wrapping (N_REQ is a power of two).
  always_comb begin
    win_found_d = 1'b0;
    win_d       = '0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_ptr_q + IDW'(k);
      if (!win_found_d && req_i[idx]) begin
        win_found_d = 1'b1;
        win_d       = idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      budget_q      <= '0;
      rr_ptr_q      <= '0;
      winner_q      <= '0;
      lfsr_adv_q    <= 1'b0;
      grant_q       <= '0;
      spawn_valid_q <= 1'b0;
      spawn_x_q     <= '0;
      spawn_speed_q <= '0;
      spawn_id_q    <= '0;
    end else begin
      lfsr_adv_q    <= 1'b0;
      grant_q       <= '0;
      spawn_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (budget_q != 4'd0 && win_found_d) begin
          state_q    <= ADV;
          winner_q   <= win_d;
          lfsr_adv_q <= 1'b1;
        end
        ADV:  state_q <= WAIT;
        // rand_in has settled after the advance; capture it into the ISSUE outputs.
        WAIT: begin
          state_q       <= ISSUE;
          spawn_valid_q <= 1'b1;
          grant_q       <= ONE_HOT0 << winner_q;
          spawn_x_q     <= spawn_x_d;
          spawn_speed_q <= rand_in_i[12:10] | 3'b001;
          spawn_id_q    <= winner_q;
        end
        ISSUE: begin
          state_q  <= IDLE;
          rr_ptr_q <= winner_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      // A reload in the ISSUE cycle wins over the decrement.
      if (frame_tick_i)
        budget_q <= quota_d;
      else if (state_q == ISSUE && budget_q != 4'd0)
        budget_q <= budget_q - 4'd1;
    end
  end

  assign lfsr_adv_o    = lfsr_adv_q;
  assign grant_o       = grant_q;
  assign spawn_valid_o = spawn_valid_q;
  assign spawn_x_o     = spawn_x_q;
  assign spawn_speed_o = spawn_speed_q;
  assign spawn_id_o    = spawn_id_q;

endmodule

// File: tb/tb_flake_spawn_sched.sv
// Bench for flake_spawn_sched: event-time reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_flake_spawn_sched;
  localparam int N  = 4;
  localparam int XM = 639;

  logic         clk = 1'b0, rst = 1'b0, frame_tick = 1'b0;
  logic [3:0]   level = '0;
  logic [N-1:0] req = '0;
  logic [23:0]  rand_in = '0;
  logic         lfsr_adv, spawn_valid;
  logic [N-1:0] grant;
  logic [9:0]   spawn_x;
  logic [2:0]   spawn_speed;
  logic [1:0]   spawn_id;

  flake_spawn_sched #(.N_REQ(N), .X_MAX(XM)) dut (
    .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick), .level_i(level),
    .req_i(req), .rand_in_i(rand_in), .lfsr_adv_o(lfsr_adv), .grant_o(grant),
    .spawn_valid_o(spawn_valid), .spawn_x_o(spawn_x), .spawn_speed_o(spawn_speed),
    .spawn_id_o(spawn_id)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int pcyc = 0, adv_cnt = 0, last_adv = 0, grant_cnt = 0;
  logic [23:0] rand_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic logic [9:0] fold(input logic [9:0] r);
    return (int'(r) > XM) ? r - 10'd512 : r;
  endfunction

  // Reference model: a spawn started at edge s shows adv after edge s, issue after
  // s+2, and commits pointer/budget at s+3; a new one may start at s+4.
  int m_cyc = 0, m_start = -100, m_win = 0, m_ptr = 0, m_bud = 0;
  logic         ex_adv = 0, ex_val = 0;
  logic [N-1:0] ex_grant = '0;
  logic [9:0]   ex_x = '0;
  logic [2:0]   ex_spd = '0;
  logic [1:0]   ex_id = '0;

  initial forever begin
    int c, s, w;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_cyc = 0; m_start = -100; m_win = 0; m_ptr = 0; m_bud = 0;
      ex_adv = 0; ex_val = 0; ex_grant = '0; ex_x = '0; ex_spd = '0; ex_id = '0;
    end else begin
      c = m_cyc + 1; s = m_start; w = m_win;
      if (c >= s + 4 && m_bud != 0 && req != '0) begin
        s = c;
        w = pick(req, m_ptr);
      end
      ex_adv   = (c == s);
      ex_val   = (c == s + 2);
      ex_grant = ex_val ? N'(1 << w) : '0;
      if (ex_val) begin
        ex_x   = fold(rand_in[9:0]);
        ex_spd = rand_in[12:10] | 3'b001;
        ex_id  = 2'(w);
      end
      if (frame_tick) m_bud = (level > 4'd8) ? 8 : int'(level);
      else if (c == s + 3 && m_bud != 0) m_bud = m_bud - 1;
      if (c == s + 3) m_ptr = (w + 1) % N;
      m_cyc = c; m_start = s; m_win = w;
    end
  end

  initial forever begin
    @(posedge clk);
    pcyc++;
  end

  // Stand-in LFSR: a new word appears after each advance (directed words first).
  initial forever begin
    @(negedge clk);
    if (lfsr_adv === 1'b1) begin
      rand_in = (rand_q.size() > 0) ? rand_q.pop_front() : 24'($urandom);
      adv_cnt++;
      last_adv = pcyc;
    end
    if (grant !== '0) grant_cnt++;
  end

  initial forever begin
    @(negedge clk);
    tests++;
    if ({lfsr_adv, spawn_valid, grant, spawn_id, spawn_speed, spawn_x} !==
        {ex_adv, ex_val, ex_grant, ex_id, ex_spd, ex_x}) begin
      fails++;
      $display("FAIL cycle %0d (got/expected): adv %b/%b valid %b/%b grant %b/%b id %0d/%0d spd %0d/%0d x %0d/%0d",
               pcyc, lfsr_adv, ex_adv, spawn_valid, ex_val, grant, ex_grant,
               spawn_id, ex_id, spawn_speed, ex_spd, spawn_x, ex_x);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (tests %0d)", tests);
    $fatal(1);
  end

  task automatic wait_valid(input int max, output bit found);
    found = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (spawn_valid === 1'b1) begin found = 1; break; end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); #2 rst = 1'b1;
  endtask

  task automatic tick(input logic [3:0] lv);
    @(negedge clk); level = lv; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  initial begin
    bit f;
    int prev, a0, g0;
    check("model_fold_1000", 32'(fold(10'd1000)), 488);
    check("model_fold_640", 32'(fold(10'd640)), 128);
    check("model_pick_wrap", pick(4'b0011, 2), 0);

    // reset held with requests and ticks active
    level = 4'd8; req = '1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); frame_tick = ~frame_tick; end
    check("rst_adv_never", adv_cnt, 0);
    check("rst_outputs", {grant, spawn_valid, spawn_x, spawn_speed, spawn_id}, 0);
    @(negedge clk); frame_tick = 1'b0; req = '0; #2 rst = 1'b1;

    // single spawn
    rand_q.push_back(24'h000C05);
    tick(4'd3);
    req = 4'b0100;
    wait_valid(10, f);
    check("single_found", f, 1);
    check("single_grant", grant, 4'b0100);
    check("single_id", spawn_id, 2);
    check("single_x", spawn_x, 5);
    check("single_speed", spawn_speed, 3);
    check("single_adv_lag", pcyc - last_adv, 2);
    check("single_adv_once", adv_cnt, 1);
    @(negedge clk); req = '0;
    check("single_one_cycle", spawn_valid, 0);

    // round-robin
    reset_dut();
    tick(4'd8);
    req = 4'hF; prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_valid(10, f);
      check("rr_found", f, 1);
      check("rr_id", spawn_id, i);
      if (i > 0) check("rr_spacing", pcyc - prev, 4);
      prev = pcyc;
      req[i] = 1'b0;
    end

    // budget exhaustion and refill
    reset_dut();
    tick(4'd2);
    req = 4'hF;
    for (int i = 0; i < 2; i++) begin
      wait_valid(10, f); check("budget_found", f, 1); check("budget_id", spawn_id, i);
    end
    wait_valid(30, f);
    check("budget_silence", f, 0);
    tick(4'd2);
    for (int i = 2; i < 4; i++) begin
      wait_valid(10, f); check("refill_found", f, 1); check("refill_id", spawn_id, i);
    end
    req = '0;

    // fold and speed
    repeat (5) @(negedge clk);
    rand_q.push_back(24'h0003E8);
    rand_q.push_back(24'h00027F);
    rand_q.push_back(24'h000280);
    tick(4'd3);
    req = 4'b0001;
    wait_valid(10, f); check("fold_1000_x", spawn_x, 488); check("fold_1000_spd", spawn_speed, 1);
    wait_valid(10, f); check("fold_639_x", spawn_x, 639);
    wait_valid(10, f); check("fold_640_x", spawn_x, 128);
    req = '0;

    // pause at level 0
    repeat (6) @(negedge clk);
    tick(4'd0);
    req = 4'hF; a0 = adv_cnt;
    repeat (50) @(negedge clk);
    check("pause_no_adv", adv_cnt - a0, 0);

    // reset dropped during WAIT
    tick(4'd5);
    f = 0;
    for (int i = 0; i < 10 && !f; i++) begin @(negedge clk); if (lfsr_adv === 1'b1) f = 1; end
    check("mid_adv_seen", f, 1);
    @(negedge clk); #2 rst = 1'b0;
    g0 = grant_cnt;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    wait_valid(20, f);
    check("mid_no_spawn", f, 0);
    check("mid_no_grant", grant_cnt - g0, 0);
    tick(4'd5);
    wait_valid(10, f);
    check("mid_resume", f, 1);
    req = '0;

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      req = N'($urandom);
      if ($urandom_range(0, 7) == 0) level = 4'($urandom);
      frame_tick = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 249) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
      end
    end
    @(negedge clk); req = '0; frame_tick = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
